// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared constants and status bundle for the SRAM-backed FIFO controller.
// Imported by the pointer, interface and top-level files.
package sram_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 10;
    localparam int AEMPTY_LVL_DEF = 4;

    // Occupancy flags derived from the two pointers.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Single-port synchronous SRAM bus between the FIFO controller and memory.
// Ports: sram_addr/sram_we/sram_wdata (controller -> SRAM),
//        sram_rdata (SRAM -> controller, valid one cycle after the address).
interface sram_fifo_ctrl_if
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

    logic [ADDR_WIDTH-1:0] sram_addr;
    logic                  sram_we;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport master (
        output sram_addr,
        output sram_we,
        output sram_wdata,
        input  sram_rdata
    );

    modport slave (
        input  sram_addr,
        input  sram_we,
        input  sram_wdata,
        output sram_rdata
    );

endinterface

// File: rtl/sram_fifo_ctrl_ptr.sv
// Wrapping FIFO pointer: AW address bits plus one wrap bit.
// Ports: clk, rst (sync, high), clear (sync flush), en (advance), ptr.
module fifo_ptr
    import sram_fifo_pkg::*;
#(
    parameter int AW = ADDR_WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    output logic [AW:0] ptr
);

    // Natural binary overflow of the AW+1 bit register wraps the
    // address from DEPTH-1 to 0 and toggles the wrap bit.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over a single-port SRAM with one-cycle read latency.
// Writes win the SRAM port; a pop is granted only on cycles without a push.
// Ports: clk, rst (sync, high), clear (sync flush)
//        wr_en/wr_data          push side
//        rd_req/rd_grant        pop request / accepted this cycle
//        rd_valid/rd_data       popped word, one cycle after rd_grant
//        sram (master modport)  SRAM address/strobe/data bus
//        full, empty, almost_full, almost_empty, count   status
//        overflow, underflow    sticky errors
// Option: define SRAM_FIFO_ERR_EN to build the sticky error flags;
//         otherwise overflow/underflow are tied to 0.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int AFULL_LVL  = (2 ** ADDR_WIDTH) - 4,
    parameter int AEMPTY_LVL = AEMPTY_LVL_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    output logic                  rd_grant,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    sram_fifo_ctrl_if.master      sram,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] AFULL_C  = AFULL_LVL[AW:0];
    localparam logic [AW:0] AEMPTY_C = AEMPTY_LVL[AW:0];

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         push_ok;
    fifo_status_t st;

    // Reset and clear silence both SRAM operations in their own cycle.
    assign push_ok  = wr_en & ~st.full & ~clear & ~rst;
    assign rd_grant = rd_req & ~st.empty & ~push_ok & ~clear & ~rst;

    fifo_ptr #(.AW(AW)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (push_ok),
        .ptr   (wptr)
    );

    fifo_ptr #(.AW(AW)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (rd_grant),
        .ptr   (rptr)
    );

    // Modular difference of the wrap-extended pointers is the occupancy.
    assign count = wptr - rptr;

    always_comb begin
        st              = '0;
        st.empty        = (wptr == rptr);
        st.full         = (wptr[AW-1:0] == rptr[AW-1:0])
                        & (wptr[AW] != rptr[AW]);
        st.almost_full  = (count >= AFULL_C);
        st.almost_empty = (count <= AEMPTY_C);
    end

    assign full         = st.full;
    assign empty        = st.empty;
    assign almost_full  = st.almost_full;
    assign almost_empty = st.almost_empty;

    // Idle cycles park the address on the read pointer.
    assign sram.sram_addr  = push_ok ? wptr[AW-1:0] : rptr[AW-1:0];
    assign sram.sram_we    = push_ok;
    assign sram.sram_wdata = wr_data;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_grant;
        end
    end

    assign rd_data = sram.sram_rdata;

`ifdef SRAM_FIFO_ERR_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_en && st.full) begin
                ovf_q <= 1'b1;
            end
            if (rd_req && st.empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
